// File: rtl/audio_pdm_out_if.sv
// audio_pdm_out_if: sample/mute inputs and strobe/level/PDM outputs of the audio back-end
interface audio_pdm_out_if;
    logic [3:0] sample;
    logic       mute;
    logic       sample_ena;
    logic [7:0] level_o;
    logic       muted_o;
    logic       pdm_out;
    modport master (output sample, mute, input sample_ena, level_o, muted_o, pdm_out);
    modport slave (input sample, mute, output sample_ena, level_o, muted_o, pdm_out);
endinterface

// File: rtl/audio_pdm_out.sv
// audio_pdm_out: sample strobe, delayed sample latch, soft mute ramp and 1-bit sigma-delta output (AUDIO_DITHER_EN adds LFSR dither)
module audio_pdm_out #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int SAMPLE_RATE = 16384,
    parameter int LATCH_DELAY = 5
) (
    input logic            clock,
    input logic            reset_n,
    audio_pdm_out_if.slave bus
);
    localparam int TW = $clog2(CLK_HZ) + 1;
    localparam logic [TW-1:0] CLK_C = TW'(CLK_HZ);
    localparam logic [TW-1:0] RATE_C = TW'(SAMPLE_RATE);
    typedef enum logic [1:0] {RUN, RAMP_DOWN, MUTED, RAMP_UP} state_t;
    logic [TW-1:0] acc_q, acc_d, acc_sum;
    logic          ena_q, ena_d;
    logic [3:0]    dly_q, dly_d;
    logic          latch;
    state_t        state_q, state_d;
    logic [4:0]    gain_q, gain_d, gain_up, gain_dn;
    logic          muted_q, muted_d;
    logic [7:0]    smp;
    logic [12:0]   prod;
    logic [7:0]    level_q, level_d, lvl;
    logic [7:0]    sd_q, sd_d;
    logic [8:0]    sd_sum;
    logic          pdm_q, pdm_d;

    // fractional tick accumulator and latch delay counter (a new tick restarts the count)
    always_comb begin
        acc_sum = acc_q + RATE_C;
        ena_d   = acc_sum >= CLK_C;
        acc_d   = ena_d ? acc_sum - CLK_C : acc_sum;
        dly_d   = ena_q ? 4'(LATCH_DELAY) : (dly_q != 4'd0 ? dly_q - 4'd1 : 4'd0);
        latch   = dly_q == 4'd1;
    end

    // gain FSM: on each tick the mute level picks the ramp direction, saturating at 0 and 16
    always_comb begin
        gain_up = gain_q == 5'd16 ? 5'd16 : gain_q + 5'd1;
        gain_dn = gain_q == 5'd0 ? 5'd0 : gain_q - 5'd1;
        state_d = state_q;
        gain_d  = gain_q;
        if (ena_q) begin
            gain_d  = bus.mute ? gain_dn : gain_up;
            state_d = bus.mute ? (gain_dn == 5'd0 ? MUTED : RAMP_DOWN) : (gain_up == 5'd16 ? RUN : RAMP_UP);
        end
        muted_d = state_d == MUTED;
    end

    // level scaling with the pre-tick gain, then first-order sigma-delta modulation
    always_comb begin
        smp     = {~bus.sample[3], bus.sample[2:0], 4'b0000};
        prod    = {{5{smp[7]}}, smp} * {8'b0, gain_q};
        level_d = latch ? 8'd128 + prod[11:4] : level_q;
        sd_sum  = {1'b0, sd_q} + {1'b0, lvl};
        sd_d    = sd_sum[7:0];
        pdm_d   = sd_sum[8];
    end

`ifdef AUDIO_DITHER_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? 8'h1d : 8'h00);
    assign lvl    = level_q ^ {7'b0, lfsr_q[0]};
    // dither LFSR steps every clock to break up idle tones
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) lfsr_q <= 8'hCF;
        else lfsr_q <= lfsr_d;
`else
    assign lvl = level_q;
`endif

    // state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            ena_q   <= 1'b0;
            dly_q   <= 4'd0;
            state_q <= RAMP_UP;
            gain_q  <= 5'd0;
            muted_q <= 1'b0;
            level_q <= 8'd128;
            sd_q    <= 8'd0;
            pdm_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            ena_q   <= ena_d;
            dly_q   <= dly_d;
            state_q <= state_d;
            gain_q  <= gain_d;
            muted_q <= muted_d;
            level_q <= level_d;
            sd_q    <= sd_d;
            pdm_q   <= pdm_d;
        end
    end

    assign bus.sample_ena = ena_q;
    assign bus.level_o    = level_q;
    assign bus.muted_o    = muted_q;
    assign bus.pdm_out    = pdm_q;
endmodule

// File: tb/tb_audio_pdm_out.sv
// tb_audio_pdm_out: randomized self-checking bench against a tick-time reference model
module tb_audio_pdm_out;
    localparam int CLK_HZ = 1024;
    localparam int SR = 256;
    localparam int LD = 3;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int k = 0;
    int last_tick = -1000;
    int m_gain = 0;
    int m_level = 128;
    bit m_ena = 1'b0;
    bit m_muted = 1'b0;

    audio_pdm_out_if bus();
    audio_pdm_out_if bus5();
    assign bus5.sample = bus.sample;
    assign bus5.mute = bus.mute;

    audio_pdm_out #(.CLK_HZ(CLK_HZ), .SAMPLE_RATE(SR), .LATCH_DELAY(LD)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
    audio_pdm_out #(.CLK_HZ(CLK_HZ), .SAMPLE_RATE(SR), .LATCH_DELAY(5)) dut5 (.clock(clock), .reset_n(reset_n), .bus(bus5));

    always #5 clock = ~clock;

    // tick after edge n exactly when n*SR crosses a multiple of CLK_HZ
    function automatic bit tick_at(int n);
        return n > 0 && (n * SR) / CLK_HZ != ((n - 1) * SR) / CLK_HZ;
    endfunction

    // reference model: tick times, gain walk, and level latched LD+1 edges after the most recent tick
    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            k = 0; last_tick = -1000; m_gain = 0; m_level = 128; m_ena = 1'b0; m_muted = 1'b0;
        end else begin
            k++;
            if (last_tick == k - LD - 1) m_level = 128 + (((int'(bus.sample) * 16 - 128) * m_gain) >>> 4);
            if (tick_at(k - 1)) begin
                m_gain = bus.mute ? (m_gain > 0 ? m_gain - 1 : 0) : (m_gain < 16 ? m_gain + 1 : 16);
                m_muted = bus.mute && m_gain == 0;
                last_tick = k - 1;
            end
            m_ena = tick_at(k);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, want test completion");
        $fatal(1);
    end

    task automatic test_reset();
        bus.sample = 4'hF;
        bus.mute = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({bus.sample_ena, bus.pdm_out, bus.muted_o, bus.level_o} !== {3'b000, 8'd128}) begin
            n_fail++;
            $display("FAIL reset_state: ena/pdm/muted/level=%b/%b/%b/%0d want 0/0/0/128", bus.sample_ena, bus.pdm_out, bus.muted_o, bus.level_o);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_tick();
        int first;
        bit prev;
        first = 0;
        prev = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            n_checks++;
            if (bus.sample_ena !== m_ena) begin
                n_fail++;
                $display("FAIL tick_c%0d: sample_ena=%b want %b", c, bus.sample_ena, m_ena);
            end
            n_checks++;
            if (bus.sample_ena === 1'b1 && prev) begin
                n_fail++;
                $display("FAIL tick_adjacent_c%0d: sample_ena=1 on two clocks, want a gap", c);
            end
            if (bus.sample_ena === 1'b1 && first == 0) first = c;
            prev = bus.sample_ena;
        end
        n_checks++;
        if (first != 4) begin
            n_fail++;
            $display("FAIL first_tick: first strobe on clock %0d want 4", first);
        end
    endtask

    task automatic test_ramp_up();
        logic [7:0] pl;
        pl = 8'd128;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.sample_ena, bus.level_o, bus.muted_o} !== {m_ena, 8'(m_level), m_muted}) begin
                n_fail++;
                $display("FAIL ramp_up_c%0d: ena/level/muted=%b/%0d/%b want %b/%0d/%b", c, bus.sample_ena, bus.level_o, bus.muted_o, m_ena, m_level, m_muted);
            end
            n_checks++;
            if (bus.level_o < pl) begin
                n_fail++;
                $display("FAIL ramp_monotonic_c%0d: level=%0d want >= %0d", c, bus.level_o, pl);
            end
            pl = bus.level_o;
        end
        n_checks++;
        if ({bus.level_o, bus.muted_o} !== {8'd240, 1'b0}) begin
            n_fail++;
            $display("FAIL ramp_up_end: level/muted=%0d/%b want 240/0", bus.level_o, bus.muted_o);
        end
    endtask

`ifndef AUDIO_DITHER_EN
    task automatic test_pdm();
        int ones;
        bit prev;
        bus.sample = 4'hF;
        repeat (12) @(negedge clock);
        ones = 0;
        repeat (256) begin @(negedge clock); ones += int'(bus.pdm_out); end
        n_checks++;
        if (ones != 240) begin
            n_fail++;
            $display("FAIL pdm_full: ones=%0d want 240", ones);
        end
        bus.sample = 4'h8;
        repeat (12) @(negedge clock);
        prev = bus.pdm_out;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            n_checks++;
            if (bus.pdm_out === prev) begin
                n_fail++;
                $display("FAIL pdm_alternate_c%0d: pdm=%b want %b", c, bus.pdm_out, ~prev);
            end
            prev = bus.pdm_out;
        end
        bus.sample = 4'h0;
        repeat (12) @(negedge clock);
        for (int c = 0; c < 32; c++) begin
            @(negedge clock);
            n_checks++;
            if (bus.pdm_out !== 1'b0) begin
                n_fail++;
                $display("FAIL pdm_zero_c%0d: pdm=%b want 0", c, bus.pdm_out);
            end
        end
        for (int r = 0; r < 3; r++) begin
            bus.sample = 4'($urandom_range(15));
            repeat (12) @(negedge clock);
            ones = 0;
            repeat (256) begin @(negedge clock); ones += int'(bus.pdm_out); end
            n_checks++;
            if (ones != m_level) begin
                n_fail++;
                $display("FAIL pdm_rand%0d: sample=%0d ones=%0d want %0d", r, bus.sample, ones, m_level);
            end
        end
    endtask
`else
    task automatic test_dither();
        int ones;
        bit prev, periodic;
        bus.sample = 4'h8;
        bus.mute = 1'b0;
        repeat (80) @(negedge clock);
        ones = 0;
        periodic = 1'b1;
        prev = bus.pdm_out;
        repeat (1024) begin
            @(negedge clock);
            ones += int'(bus.pdm_out);
            if (bus.pdm_out === prev) periodic = 1'b0;
            prev = bus.pdm_out;
        end
        n_checks++;
        if (periodic) begin
            n_fail++;
            $display("FAIL dither_periodic: pdm period-2 alternating, want broken pattern");
        end
        n_checks++;
        if (ones < 510 || ones > 514) begin
            n_fail++;
            $display("FAIL dither_ones: ones=%0d want 510..514", ones);
        end
    endtask
`endif

    task automatic test_mute();
        int waited;
        bus.sample = 4'hF;
        bus.mute = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.sample_ena, bus.level_o, bus.muted_o} !== {m_ena, 8'(m_level), m_muted}) begin
                n_fail++;
                $display("FAIL mute_down_c%0d: ena/level/muted=%b/%0d/%b want %b/%0d/%b", c, bus.sample_ena, bus.level_o, bus.muted_o, m_ena, m_level, m_muted);
            end
        end
        n_checks++;
        if ({bus.level_o, bus.muted_o} !== {8'd128, 1'b1}) begin
            n_fail++;
            $display("FAIL muted_end: level/muted=%0d/%b want 128/1", bus.level_o, bus.muted_o);
        end
        bus.mute = 1'b0;
        repeat (80) @(negedge clock);
        bus.mute = 1'b1;
        waited = 0;
        while (m_gain != 8 && waited < 100) begin
            @(negedge clock);
            waited++;
            n_checks++;
            if ({bus.level_o, bus.muted_o} !== {8'(m_level), m_muted}) begin
                n_fail++;
                $display("FAIL mute_to8_c%0d: level/muted=%0d/%b want %0d/%b", waited, bus.level_o, bus.muted_o, m_level, m_muted);
            end
        end
        n_checks++;
        if (waited >= 100) begin
            n_fail++;
            $display("FAIL mute_to8_timeout: waited=%0d cycles want < 100", waited);
        end
        bus.mute = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.sample_ena, bus.level_o, bus.muted_o} !== {m_ena, 8'(m_level), m_muted}) begin
                n_fail++;
                $display("FAIL unmute_c%0d: ena/level/muted=%b/%0d/%b want %b/%0d/%b", c, bus.sample_ena, bus.level_o, bus.muted_o, m_ena, m_level, m_muted);
            end
        end
        n_checks++;
        if (bus.level_o !== 8'd240) begin
            n_fail++;
            $display("FAIL unmute_end: level=%0d want 240", bus.level_o);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.sample_ena, bus.level_o, bus.muted_o} !== {m_ena, 8'(m_level), m_muted}) begin
                n_fail++;
                $display("FAIL random_c%0d: ena/level/muted=%b/%0d/%b want %b/%0d/%b", c, bus.sample_ena, bus.level_o, bus.muted_o, m_ena, m_level, m_muted);
            end
            if ($urandom_range(29) == 0) bus.mute = ~bus.mute;
            if ($urandom_range(9) == 0) bus.sample = 4'($urandom_range(15));
        end
    endtask

    task automatic test_latch_restart();
        bus.mute = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            n_checks++;
            if ({bus5.level_o, bus5.sample_ena} !== {8'd128, m_ena}) begin
                n_fail++;
                $display("FAIL latch_restart_c%0d: level/ena=%0d/%b want 128/%b", c, bus5.level_o, bus5.sample_ena, m_ena);
            end
            if ($urandom_range(3) == 0) bus.sample = 4'($urandom_range(15));
        end
    endtask

    task automatic test_reset_mid();
        bus.sample = 4'hF;
        bus.mute = 1'b0;
        repeat (80) @(negedge clock);
        bus.mute = 1'b1;
        repeat (22) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (bus.level_o !== 8'd128) begin
            n_fail++;
            $display("FAIL reset_mid_level: level=%0d want 128", bus.level_o);
        end
        n_checks++;
        if ({bus.pdm_out, bus.sample_ena, bus.muted_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_bits: pdm/ena/muted=%b/%b/%b want 0/0/0", bus.pdm_out, bus.sample_ena, bus.muted_o);
        end
        @(negedge clock);
        reset_n = 1'b1;
        bus.mute = 1'b0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.sample_ena, bus.level_o, bus.muted_o} !== {m_ena, 8'(m_level), m_muted}) begin
                n_fail++;
                $display("FAIL reset_restart_c%0d: ena/level/muted=%b/%0d/%b want %b/%0d/%b", c, bus.sample_ena, bus.level_o, bus.muted_o, m_ena, m_level, m_muted);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick();
        test_ramp_up();
`ifndef AUDIO_DITHER_EN
        test_pdm();
`else
        test_dither();
`endif
        test_mute();
        test_random();
        test_latch_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
